// File: rtl/vga_scan_generator.sv
// vga_scan_generator
// Raster timing generator for a 640x480@60 frame (800x525 totals).
// Sweeps hCnt/vCnt and presents registered pixel coordinates, an
// active-video qualifier, active-low syncs, a start-of-frame strobe and a
// completed-frame counter to the drawing objects and the VGA output mux.
//
// Build option: define PIXEL_DIV2_EN to step the raster every second clk
// (e.g. 50 MHz clk -> 25 MHz pixel rate). Left undefined, pxlEn is tied
// high and the raster steps on every clk.
//
// Both totals must fit the 10-bit internal counters (<= 1024).
module vga_scan_generator #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic               clk,
  input  logic               resetN,
  output logic signed [10:0] pixelX,
  output logic signed [10:0] pixelY,
  output logic               activeVideo,
  output logic               hSyncN,
  output logic               vSyncN,
  output logic               pxlEn,
  output logic               startOfFrame,
  output logic [7:0]         frameCount
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // Counter values at which each region begins (front porch, sync, back
  // porch) and the last count before wrapping back to the active region.
  localparam logic [9:0] H_FP_START   = 10'(H_ACTIVE);
  localparam logic [9:0] H_SYNC_START = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] H_BP_START   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] H_LAST       = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_FP_START   = 10'(V_ACTIVE);
  localparam logic [9:0] V_SYNC_START = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] V_BP_START   = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [9:0] V_LAST       = 10'(V_TOTAL - 1);

  // Region of the scan; the same encoding serves both axes.
  typedef enum logic [1:0] {
    ST_ACT  = 2'd0,
    ST_FP   = 2'd1,
    ST_SYNC = 2'd2,
    ST_BP   = 2'd3
  } scan_state_t;

  // Raster position and frame count (state that the outputs are derived from)
  logic [9:0]  r_h_cnt;
  logic [9:0]  r_v_cnt;
  logic [7:0]  r_frame_cnt;
  scan_state_t r_h_state;
  scan_state_t r_v_state;

  // Next-step values
  logic [9:0]  w_h_cnt_next;
  logic [9:0]  w_v_cnt_next;
  logic [7:0]  w_frame_cnt_next;
  scan_state_t w_h_state_next;
  scan_state_t w_v_state_next;
  logic        w_h_wrap;
  logic        w_v_wrap;
  logic        w_step;

`ifdef PIXEL_DIV2_EN
  logic r_phase;

  // Pixel-rate phase: low on the first clk after reset, then toggles
  always_ff @(posedge clk) begin
    if (!resetN) begin
      r_phase <= 1'b0;
    end else begin
      r_phase <= ~r_phase;
    end
  end

  assign w_step = r_phase;
`else
  assign w_step = 1'b1;
`endif

  assign pxlEn = w_step;

  // Next counter values: h wraps at the end of a line, v steps on each h wrap,
  // and a frame completes when both wrap together
  always_comb begin
    w_h_wrap         = (r_h_cnt == H_LAST);
    w_v_wrap         = (r_v_cnt == V_LAST);
    w_h_cnt_next     = w_h_wrap ? 10'd0 : r_h_cnt + 10'd1;
    w_v_cnt_next     = r_v_cnt;
    w_frame_cnt_next = r_frame_cnt;
    if (w_h_wrap) begin
      w_v_cnt_next = w_v_wrap ? 10'd0 : r_v_cnt + 10'd1;
      if (w_v_wrap) begin
        w_frame_cnt_next = r_frame_cnt + 8'd1;
      end
    end
  end

  // Horizontal region FSM: leaves each region when the next count reaches
  // the start of the following one
  always_comb begin
    w_h_state_next = r_h_state;
    unique case (r_h_state)
      ST_ACT:  if (w_h_cnt_next == H_FP_START)   w_h_state_next = ST_FP;
      ST_FP:   if (w_h_cnt_next == H_SYNC_START) w_h_state_next = ST_SYNC;
      ST_SYNC: if (w_h_cnt_next == H_BP_START)   w_h_state_next = ST_BP;
      ST_BP:   if (w_h_wrap)                     w_h_state_next = ST_ACT;
      default:                                   w_h_state_next = ST_ACT;
    endcase
  end

  // Vertical region FSM: only moves on the pixel step where the line wraps
  always_comb begin
    w_v_state_next = r_v_state;
    if (w_h_wrap) begin
      unique case (r_v_state)
        ST_ACT:  if (w_v_cnt_next == V_FP_START)   w_v_state_next = ST_FP;
        ST_FP:   if (w_v_cnt_next == V_SYNC_START) w_v_state_next = ST_SYNC;
        ST_SYNC: if (w_v_cnt_next == V_BP_START)   w_v_state_next = ST_BP;
        ST_BP:   if (w_v_wrap)                     w_v_state_next = ST_ACT;
        default:                                   w_v_state_next = ST_ACT;
      endcase
    end
  end

  // Raster state register: counters, region states and frame count step together
  always_ff @(posedge clk) begin
    if (!resetN) begin
      r_h_cnt     <= 10'd0;
      r_v_cnt     <= 10'd0;
      r_frame_cnt <= 8'd0;
      r_h_state   <= ST_ACT;
      r_v_state   <= ST_ACT;
    end else if (w_step) begin
      r_h_cnt     <= w_h_cnt_next;
      r_v_cnt     <= w_v_cnt_next;
      r_frame_cnt <= w_frame_cnt_next;
      r_h_state   <= w_h_state_next;
      r_v_state   <= w_v_state_next;
    end
  end

  // Output register: every port is loaded from the same raster position on
  // the same edge, so coordinates, qualifiers and syncs always agree. The
  // frame strobe is cleared on non-step clks so it never repeats under division.
  always_ff @(posedge clk) begin
    if (!resetN) begin
      pixelX       <= 11'sd0;
      pixelY       <= 11'sd0;
      activeVideo  <= 1'b0;
      hSyncN       <= 1'b1;
      vSyncN       <= 1'b1;
      startOfFrame <= 1'b0;
      frameCount   <= 8'd0;
    end else if (w_step) begin
      pixelX       <= $signed({1'b0, r_h_cnt});
      pixelY       <= $signed({1'b0, r_v_cnt});
      activeVideo  <= (r_h_state == ST_ACT) && (r_v_state == ST_ACT);
      hSyncN       <= (r_h_state != ST_SYNC);
      vSyncN       <= (r_v_state != ST_SYNC);
      startOfFrame <= (r_h_cnt == 10'd0) && (r_v_cnt == 10'd0);
      frameCount   <= r_frame_cnt;
    end else begin
      startOfFrame <= 1'b0;
    end
  end

endmodule
